// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//  Bundles the signals between the instruction-memory arbiter and its
//  neighbours: the FE fetch path, the program loader and the imem array.
//  Ports: none. Parameters DBITS, IMEMADDRBITS and IMEMWORDBITS size the
//  buses and must match the arbiter instance.
//  Modports:
//   master - the environment side: the FE stage, the loader and the imem
//            array. It drives requests, addresses, write data and mem_rdata.
//   slave  - the arbiter side. It drives grants, read return and the
//            imem access controls.
interface imem_port_arbiter_if #(
  parameter int DBITS        = 32,
  parameter int IMEMADDRBITS = 16,
  parameter int IMEMWORDBITS = 2
);
  // FE read port
  logic                                 fe_req;
  logic [DBITS-1:0]                     fe_addr;
  logic                                 fe_flush;
  logic                                 fe_gnt;
  logic                                 fe_rvalid;
  logic [DBITS-1:0]                     fe_rdata;
  // Loader write port
  logic                                 ld_req;
  logic [DBITS-1:0]                     ld_addr;
  logic [DBITS-1:0]                     ld_wdata;
  logic                                 ld_lock;
  logic                                 ld_gnt;
  // imem array port
  logic                                 mem_en;
  logic                                 mem_we;
  logic [IMEMADDRBITS-IMEMWORDBITS-1:0] mem_addr;
  logic [DBITS-1:0]                     mem_wdata;
  logic [DBITS-1:0]                     mem_rdata;

  modport master (
    output fe_req, fe_addr, fe_flush,
    output ld_req, ld_addr, ld_wdata, ld_lock,
    output mem_rdata,
    input  fe_gnt, fe_rvalid, fe_rdata, ld_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fe_req, fe_addr, fe_flush,
    input  ld_req, ld_addr, ld_wdata, ld_lock,
    input  mem_rdata,
    output fe_gnt, fe_rvalid, fe_rdata, ld_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//  Shares the single-port instruction memory between the FE fetch path
//  (reads) and the program loader (writes). At most one access is granted
//  per cycle. The loader has fixed priority, but a wait counter forces an FE
//  grant once FE has been denied MAX_FE_WAIT cycles in a row. ld_lock gives
//  the loader exclusive use of the memory. Read data comes back one cycle
//  after the grant, tagged by fe_rvalid. fe_flush squashes a fetch in flight.
//  Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - imem_port_arbiter_if.slave. It carries the FE request/grant/read
//           return, the loader request/grant/write data and the imem
//           en/we/addr/wdata/rdata signals.
module imem_port_arbiter #(
  parameter int DBITS        = 32,
  parameter int IMEMADDRBITS = 16,
  parameter int IMEMWORDBITS = 2,
  parameter int MAX_FE_WAIT  = 4
) (
  input logic                clk,
  input logic                reset,
  imem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT = 4'(MAX_FE_WAIT);

  logic [3:0] wait_cnt;
  logic       rd_pend;
  logic       fe_gnt;
  logic       ld_gnt;
  logic       fe_rvalid;
  logic       unused_addr_bits;

  // Grants are combinational so that request and grant happen in the same
  // cycle. They are also masked during reset, so that no access can reach
  // the memory while the block is held in reset.
  always_comb begin
    fe_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!reset) begin
      if (bus.ld_lock) begin
        ld_gnt = bus.ld_req;
      end else if (bus.fe_req && (wait_cnt == MAX_WAIT)) begin
        fe_gnt = 1'b1;
      end else if (bus.ld_req) begin
        ld_gnt = 1'b1;
      end else if (bus.fe_req) begin
        fe_gnt = 1'b1;
      end
    end
  end

  // The starvation counter is frozen while the loader holds the lock.
  // Otherwise it counts the consecutive cycles in which FE is denied, and
  // saturates at the threshold until FE wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= fe_gnt && !bus.fe_flush;
      if (!bus.ld_lock) begin
        if (fe_gnt || !bus.fe_req) begin
          wait_cnt <= 4'd0;
        end else if (wait_cnt != MAX_WAIT) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
    end
  end

  // A flush in the return cycle also kills the return. Reset masks the
  // return as well, so that an access caught by reset never reports valid.
  assign fe_rvalid = rd_pend && !bus.fe_flush && !reset;

  assign bus.fe_gnt    = fe_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.fe_rvalid = fe_rvalid;
  assign bus.fe_rdata  = fe_rvalid ? bus.mem_rdata : '0;

  assign bus.mem_en    = fe_gnt || ld_gnt;
  assign bus.mem_we    = ld_gnt;
  assign bus.mem_addr  = ld_gnt ? bus.ld_addr[IMEMADDRBITS-1:IMEMWORDBITS]
                                : bus.fe_addr[IMEMADDRBITS-1:IMEMWORDBITS];
  assign bus.mem_wdata = bus.ld_wdata;

  // The byte-offset bits and the bits above the decoded range are dropped on
  // purpose, so that addresses wrap around inside the imem.
  assign unused_addr_bits = ^{bus.fe_addr[DBITS-1:IMEMADDRBITS],
                              bus.fe_addr[IMEMWORDBITS-1:0],
                              bus.ld_addr[DBITS-1:IMEMADDRBITS],
                              bus.ld_addr[IMEMWORDBITS-1:0]};

  // The two requesters must never be granted together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fe_gnt && ld_gnt));
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
//  Directed bench for imem_port_arbiter. A behavioural imem with a registered
//  read and a write-before-next-read ordering sits on the memory side. Each
//  cycle the bench applies a stimulus vector just after the rising edge and
//  compares the outputs 1 ns later against hand-computed values.
module tb_imem_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  imem_port_arbiter_if #(.DBITS(32), .IMEMADDRBITS(16), .IMEMWORDBITS(2)) bus ();

  imem_port_arbiter #(
    .DBITS(32), .IMEMADDRBITS(16), .IMEMWORDBITS(2), .MAX_FE_WAIT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural imem: registered read, write lands at the clock edge
  logic [31:0] imem [0:16383];

  function automatic logic [31:0] memInit(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) imem[i] <= memInit(i);
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) imem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= imem[bus.mem_addr];
    end
  end

  task automatic applyStimulus(input logic rst, input logic fr, input logic [31:0] fa,
                               input logic ff, input logic lr, input logic [31:0] la,
                               input logic [31:0] lw, input logic ll);
    reset        = rst;
    bus.fe_req   = fr;
    bus.fe_addr  = fa;
    bus.fe_flush = ff;
    bus.ld_req   = lr;
    bus.ld_addr  = la;
    bus.ld_wdata = lw;
    bus.ld_lock  = ll;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset held with both requesters active: nothing may be granted
    applyStimulus(1, 1, 32'h200, 0, 1, 32'h40, 32'h1, 0);
    checkOutput("rst_fe_gnt", 32'(bus.fe_gnt), 0);
    checkOutput("rst_ld_gnt", 32'(bus.ld_gnt), 0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 0);
    checkOutput("rst_rvalid", 32'(bus.fe_rvalid), 0);
    checkOutput("rst_rdata", bus.fe_rdata, 0);
    stepClock();
    stepClock();

    // T1: single FE read of 0x200 -> word 0x80
    applyStimulus(0, 1, 32'h200, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t1_fe_gnt", 32'(bus.fe_gnt), 1);
    checkOutput("t1_ld_gnt", 32'(bus.ld_gnt), 0);
    checkOutput("t1_mem_en", 32'(bus.mem_en), 1);
    checkOutput("t1_mem_we", 32'(bus.mem_we), 0);
    checkOutput("t1_mem_addr", 32'(bus.mem_addr), 32'h80);
    checkOutput("t1_rvalid_early", 32'(bus.fe_rvalid), 0);
    stepClock();
    // Wrap-around: bits above 16 and the byte offset are dropped -> word 0x81
    applyStimulus(0, 1, 32'h0001_0207, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t1_rvalid", 32'(bus.fe_rvalid), 1);
    checkOutput("t1_rdata", bus.fe_rdata, memInit(32'h80));
    checkOutput("wrap_mem_addr", 32'(bus.mem_addr), 32'h81);
    stepClock();
    applyIdle();
    checkOutput("wrap_rvalid", 32'(bus.fe_rvalid), 1);
    checkOutput("wrap_rdata", bus.fe_rdata, memInit(32'h81));
    checkOutput("idle_mem_en", 32'(bus.mem_en), 0);
    stepClock();
    applyIdle();
    checkOutput("idle_rvalid", 32'(bus.fe_rvalid), 0);
    checkOutput("idle_rdata", bus.fe_rdata, 0);
    stepClock();

    // T2: both requesting for 10 cycles -> LD,LD,LD,LD,FE repeating
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h1000 + 32'(i), 0);
      checkOutput($sformatf("t2_fe_gnt_%0d", i), 32'(bus.fe_gnt), (i % 5 == 4) ? 1 : 0);
      checkOutput($sformatf("t2_ld_gnt_%0d", i), 32'(bus.ld_gnt), (i % 5 == 4) ? 0 : 1);
      checkOutput($sformatf("t2_rvalid_%0d", i), 32'(bus.fe_rvalid),
                  (i > 0 && ((i - 1) % 5 == 4)) ? 1 : 0);
      stepClock();
    end
    applyIdle();
    checkOutput("t2_rvalid_tail", 32'(bus.fe_rvalid), 1);
    checkOutput("t2_rdata_tail", bus.fe_rdata, memInit(32'hC0));
    stepClock();

    // T3: lock for 20 cycles, FE never granted, ld_gnt follows ld_req
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 32'h300, 0, logic'(i % 2), 32'h2000, 32'h55, 1);
      checkOutput($sformatf("t3_fe_gnt_%0d", i), 32'(bus.fe_gnt), 0);
      checkOutput($sformatf("t3_ld_gnt_%0d", i), 32'(bus.ld_gnt), 32'(i % 2));
      stepClock();
    end
    // The counter was frozen at 0 while locked, so FE waits four more LD grants
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h66, 0);
      checkOutput($sformatf("t3_unlock_fe_gnt_%0d", j), 32'(bus.fe_gnt), (j == 4) ? 1 : 0);
      stepClock();
    end
    applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h77, 1);
    checkOutput("t3_relock_fe_gnt", 32'(bus.fe_gnt), 0);
    stepClock();
    applyStimulus(0, 1, 32'h300, 0, 0, 32'h2000, 32'h77, 0);
    checkOutput("t3_drop_fe_gnt", 32'(bus.fe_gnt), 1);
    checkOutput("t3_drop_ld_gnt", 32'(bus.ld_gnt), 0);
    stepClock();
    applyIdle();
    stepClock();

    // T3b: the lock overrides a saturated counter, and the count is kept
    for (int j = 0; j < 4; j++) begin
      applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h88, 0);
      stepClock();
    end
    applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h99, 1);
    checkOutput("t3b_lock_fe_gnt", 32'(bus.fe_gnt), 0);
    checkOutput("t3b_lock_ld_gnt", 32'(bus.ld_gnt), 1);
    stepClock();
    applyStimulus(0, 1, 32'h300, 0, 1, 32'h2000, 32'h99, 0);
    checkOutput("t3b_unlock_fe_gnt", 32'(bus.fe_gnt), 1);
    checkOutput("t3b_unlock_ld_gnt", 32'(bus.ld_gnt), 0);
    stepClock();
    applyIdle();
    stepClock();

    // T4: a flush kills the return in flight; a flush in a grant cycle kills that grant's return
    applyStimulus(0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t4_gnt_n", 32'(bus.fe_gnt), 1);
    stepClock();
    applyStimulus(0, 1, 32'h104, 1, 0, 32'h0, 32'h0, 0);
    checkOutput("t4_rvalid_n1", 32'(bus.fe_rvalid), 0);
    checkOutput("t4_rdata_n1", bus.fe_rdata, 0);
    checkOutput("t4_gnt_n1", 32'(bus.fe_gnt), 1);
    stepClock();
    applyStimulus(0, 1, 32'h108, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t4_rvalid_n2", 32'(bus.fe_rvalid), 0);
    checkOutput("t4_gnt_n2", 32'(bus.fe_gnt), 1);
    stepClock();
    applyIdle();
    checkOutput("t4_rvalid_n3", 32'(bus.fe_rvalid), 1);
    checkOutput("t4_rdata_n3", bus.fe_rdata, memInit(32'h42));
    stepClock();

    // T5: write 0x40, then read it back on the next cycle
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h40, 32'hDEAD_BEEF, 0);
    checkOutput("t5_ld_gnt", 32'(bus.ld_gnt), 1);
    checkOutput("t5_mem_we", 32'(bus.mem_we), 1);
    checkOutput("t5_mem_addr_w", 32'(bus.mem_addr), 32'h10);
    checkOutput("t5_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    stepClock();
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t5_fe_gnt", 32'(bus.fe_gnt), 1);
    checkOutput("t5_mem_addr_r", 32'(bus.mem_addr), 32'h10);
    stepClock();
    applyIdle();
    checkOutput("t5_rvalid", 32'(bus.fe_rvalid), 1);
    checkOutput("t5_rdata", bus.fe_rdata, 32'hDEAD_BEEF);
    stepClock();

    // T6: reset in the cycle after a grant drops the access
    applyStimulus(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("t6_gnt", 32'(bus.fe_gnt), 1);
    stepClock();
    applyStimulus(1, 1, 32'h80, 0, 1, 32'h44, 32'h1, 0);
    checkOutput("t6_rst_rvalid", 32'(bus.fe_rvalid), 0);
    checkOutput("t6_rst_fe_gnt", 32'(bus.fe_gnt), 0);
    checkOutput("t6_rst_mem_en", 32'(bus.mem_en), 0);
    stepClock();
    applyIdle();
    checkOutput("t6_post_rvalid", 32'(bus.fe_rvalid), 0);
    checkOutput("t6_post_rdata", bus.fe_rdata, 0);
    checkOutput("t6_post_fe_gnt", 32'(bus.fe_gnt), 0);
    checkOutput("t6_post_ld_gnt", 32'(bus.ld_gnt), 0);
    checkOutput("t6_post_mem_en", 32'(bus.mem_en), 0);
    checkOutput("t6_post_mem_we", 32'(bus.mem_we), 0);
    stepClock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
